// File: rtl/soc_system_gol_pio_pkg.sv
// Shared constants for the GPIO block: register offsets, edge modes
// and the address-width helper.
package soc_system_gol_pio_pkg;

    localparam logic [2:0] OFF_DATA    = 3'd0;
    localparam logic [2:0] OFF_IN      = 3'd1;
    localparam logic [2:0] OFF_IRQMASK = 3'd2;
    localparam logic [2:0] OFF_EDGECAP = 3'd3;
    localparam logic [2:0] OFF_OUTSET  = 3'd4;
    localparam logic [2:0] OFF_OUTCLR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    function automatic int calc_aw(input int nch);
        return (nch <= 1) ? 3 : 3 + $clog2(nch);
    endfunction

endpackage

// File: rtl/soc_system_gol_pio_if.sv
// Register bus between a host and the GPIO block.
// Address is {channel index, 3-bit register offset}.
interface soc_system_gol_pio_if
    import soc_system_gol_pio_pkg::*;
#(
    parameter int NCH = 2
) ();

    localparam int AW = calc_aw(NCH);

    logic [AW-1:0] address;
    logic          chipselect;
    logic          write_n;
    logic          read_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic          readdatavalid;

    modport master (
        output address, chipselect, write_n, read_n, writedata,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, chipselect, write_n, read_n, writedata,
        output readdata, readdatavalid
    );

endinterface

// File: rtl/soc_system_gol_pio_chan.sv
// One GPIO channel: output register, input synchroniser and, when
// GOL_PIO_IRQ_EN is defined, edge capture with interrupt mask.
module soc_system_gol_pio_chan
    import soc_system_gol_pio_pkg::*;
#(
    parameter int             DW        = 8,
    parameter logic [DW-1:0]  RESET_VAL = '0,
    parameter int             EDGE_MODE = EDGE_RISE
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_wr_data,
    input  logic          i_wr_set,
    input  logic          i_wr_clr,
    input  logic          i_wr_mask,
    input  logic          i_wr_cap,
    input  logic [DW-1:0] i_wdata,
    input  logic [DW-1:0] i_pin,
    output logic [DW-1:0] o_data,
    output logic [DW-1:0] o_in,
    output logic [DW-1:0] o_mask,
    output logic [DW-1:0] o_cap,
    output logic          o_irq
);

    logic [DW-1:0] r_data;
    logic [DW-1:0] r_s1;
    logic [DW-1:0] r_s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= RESET_VAL;
        end else begin
            unique case (1'b1)
                i_wr_data: r_data <= i_wdata;
                i_wr_set:  r_data <= r_data | i_wdata;
                i_wr_clr:  r_data <= r_data & ~i_wdata;
                default:   r_data <= r_data;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_pin;
            r_s2 <= r_s1;
        end
    end

    assign o_data = r_data;
    assign o_in   = r_s2;

`ifdef GOL_PIO_IRQ_EN
    logic [DW-1:0] r_s3;
    logic [DW-1:0] r_mask;
    logic [DW-1:0] r_cap;
    logic [DW-1:0] w_edge;
    logic [DW-1:0] w_clr;

    always_comb begin
        w_edge = '0;
        case (EDGE_MODE)
            EDGE_FALL: w_edge = ~r_s2 & r_s3;
            EDGE_ANY:  w_edge = r_s2 ^ r_s3;
            default:   w_edge = r_s2 & ~r_s3;
        endcase
    end

    assign w_clr = i_wr_cap ? i_wdata : '0;

    // A fresh edge wins over a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s3   <= '0;
            r_mask <= '0;
            r_cap  <= '0;
        end else begin
            r_s3  <= r_s2;
            r_cap <= (r_cap & ~w_clr) | w_edge;
            if (i_wr_mask) begin
                r_mask <= i_wdata;
            end
        end
    end

    assign o_mask = r_mask;
    assign o_cap  = r_cap;
    assign o_irq  = |(r_cap & r_mask);
`else
    logic w_unused;

    assign w_unused = i_wr_mask | i_wr_cap;
    assign o_mask   = '0;
    assign o_cap    = '0;
    assign o_irq    = 1'b0;
`endif

endmodule

// File: rtl/soc_system_gol_pio.sv
// Multi-channel GPIO with register bus; interrupt logic is built
// only when GOL_PIO_IRQ_EN is defined.
module soc_system_gol_pio
    import soc_system_gol_pio_pkg::*;
#(
    parameter int            DW        = 8,
    parameter int            NCH       = 2,
    parameter logic [DW-1:0] RESET_VAL = '0,
    parameter int            EDGE_MODE = EDGE_RISE
) (
    input  logic                clk,
    input  logic                reset,
    soc_system_gol_pio_if.slave bus,
    output logic [NCH*DW-1:0]   out_port,
    input  logic [NCH*DW-1:0]   in_port,
    output logic                irq
);

    localparam int AW = calc_aw(NCH);
    localparam int CW = (AW > 3) ? AW - 3 : 1;

    logic          w_wr;
    logic          w_rd;
    logic [2:0]    w_off;
    logic [CW-1:0] w_chan;
    logic [DW-1:0] w_rmux;
    logic [DW-1:0] w_data [NCH];
    logic [DW-1:0] w_in   [NCH];
    logic [DW-1:0] w_mask [NCH];
    logic [DW-1:0] w_cap  [NCH];
    logic [NCH-1:0] w_irq_vec;
    logic [31:0]   r_rdata;
    logic          r_rdv;

    // Write wins when both strobes are low
    assign w_wr  = bus.chipselect & ~bus.write_n;
    assign w_rd  = bus.chipselect & ~bus.read_n & bus.write_n;
    assign w_off = bus.address[2:0];

    generate
        if (AW > 3) begin : g_chan_idx
            assign w_chan = bus.address[AW-1:3];
        end else begin : g_chan_zero
            assign w_chan = '0;
        end
    endgenerate

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic w_hit;

        assign w_hit = w_wr && (32'(w_chan) == 32'(c));

        soc_system_gol_pio_chan #(
            .DW        (DW),
            .RESET_VAL (RESET_VAL),
            .EDGE_MODE (EDGE_MODE)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .i_wr_data (w_hit && (w_off == OFF_DATA)),
            .i_wr_set  (w_hit && (w_off == OFF_OUTSET)),
            .i_wr_clr  (w_hit && (w_off == OFF_OUTCLR)),
            .i_wr_mask (w_hit && (w_off == OFF_IRQMASK)),
            .i_wr_cap  (w_hit && (w_off == OFF_EDGECAP)),
            .i_wdata   (bus.writedata[DW-1:0]),
            .i_pin     (in_port[c*DW +: DW]),
            .o_data    (w_data[c]),
            .o_in      (w_in[c]),
            .o_mask    (w_mask[c]),
            .o_cap     (w_cap[c]),
            .o_irq     (w_irq_vec[c])
        );

        assign out_port[c*DW +: DW] = w_data[c];
    end

    // Channel indices at or above NCH match no slot and read as zero
    always_comb begin
        w_rmux = '0;
        for (int c = 0; c < NCH; c++) begin
            if (32'(w_chan) == 32'(c)) begin
                case (w_off)
                    OFF_DATA:    w_rmux = w_data[c];
                    OFF_IN:      w_rmux = w_in[c];
                    OFF_IRQMASK: w_rmux = w_mask[c];
                    OFF_EDGECAP: w_rmux = w_cap[c];
                    default:     w_rmux = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
            r_rdv   <= 1'b0;
        end else begin
            r_rdv <= w_rd;
            if (w_rd) begin
                r_rdata <= 32'(w_rmux);
            end
        end
    end

    assign bus.readdata      = r_rdata;
    assign bus.readdatavalid = r_rdv;

`ifdef GOL_PIO_IRQ_EN
    logic r_irq;
    logic w_unused;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |w_irq_vec;
        end
    end

    assign irq      = r_irq;
    assign w_unused = ^bus.writedata;
`else
    logic w_unused;

    assign irq      = 1'b0;
    assign w_unused = ^{bus.writedata, w_irq_vec};
`endif

endmodule

// File: tb/tb_soc_system_gol_pio.sv
// Bench for soc_system_gol_pio: directed scenarios plus randomized
// register traffic against a register-level model.
module tb_soc_system_gol_pio;

    localparam int NCH = 3;
    localparam int DW  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH*DW-1:0] out_port;
    logic [NCH*DW-1:0] in_port;
    logic              irq;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_data [NCH];
    logic [7:0] m_mask [NCH];
    logic [7:0] m_cap  [NCH];

    soc_system_gol_pio_if #(.NCH(NCH)) bus ();

    soc_system_gol_pio #(
        .DW        (DW),
        .NCH       (NCH),
        .RESET_VAL (8'hA5),
        .EDGE_MODE (0)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .out_port (out_port),
        .in_port  (in_port),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] addr(input int ch, input int off);
        return 5'((ch << 3) | off);
    endfunction

    function automatic logic [23:0] exp_out();
        return {m_data[2], m_data[1], m_data[0]};
    endfunction

    function automatic logic exp_irq();
        logic r;
        r = 1'b0;
`ifdef GOL_PIO_IRQ_EN
        for (int c = 0; c < NCH; c++) r = r | (|(m_cap[c] & m_mask[c]));
`endif
        return r;
    endfunction

    function automatic logic [31:0] exp_read(input int ch, input int off);
        if (ch >= NCH) return 32'h0;
        case (off)
            0: return {24'h0, m_data[ch]};
            1: return {24'h0, in_port[ch*8 +: 8]};
`ifdef GOL_PIO_IRQ_EN
            2: return {24'h0, m_mask[ch]};
            3: return {24'h0, m_cap[ch]};
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic void model_write(input int ch, input int off,
                                        input logic [7:0] d);
        if (ch >= NCH) return;
        case (off)
            0: m_data[ch] = d;
            4: m_data[ch] = m_data[ch] | d;
            5: m_data[ch] = m_data[ch] & ~d;
`ifdef GOL_PIO_IRQ_EN
            2: m_mask[ch] = d;
            3: m_cap[ch]  = m_cap[ch] & ~d;
`endif
            default: ;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_write(input int ch, input int off, input logic [31:0] d);
        bus.address    = addr(ch, off);
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        model_write(ch, off, d[7:0]);
    endtask

    task automatic do_read(input int ch, input int off,
                           output logic [31:0] d, output logic v);
        bus.address    = addr(ch, off);
        bus.chipselect = 1'b1;
        bus.read_n     = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
        d = bus.readdata;
        v = bus.readdatavalid;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        v;
        reset = 1'b1;
        tick(2);
        total++;
        if (out_port !== 24'hA5A5A5 || irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_out: out=%h irq=%b want a5a5a5/0", out_port, irq);
        end
        do_read(0, 0, d, v);
        total++;
        if (d !== 32'h0 || v !== 1'b0) begin
            bad++;
            $display("FAIL reset_read: data=%h vld=%b want 0/0", d, v);
        end
        reset = 1'b0;
        tick(1);
        // read sampled, then reset hits before the pulse would end
        bus.address    = addr(0, 0);
        bus.chipselect = 1'b1;
        bus.read_n     = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
        reset = 1'b1;
        #1;
        total++;
        if (bus.readdatavalid !== 1'b0) begin
            bad++;
            $display("FAIL reset_inflight: vld=%b want 0", bus.readdatavalid);
        end
        tick(1);
        reset = 1'b0;
        tick(1);
        do_read(0, 0, d, v);
        total++;
        if (d !== 32'h000000A5 || v !== 1'b1) begin
            bad++;
            $display("FAIL reset_val_read: data=%h vld=%b want a5/1", d, v);
        end
        tick(1);
        total++;
        if (bus.readdatavalid !== 1'b0 || bus.readdata !== 32'h000000A5) begin
            bad++;
            $display("FAIL read_hold: data=%h vld=%b want a5/0",
                     bus.readdata, bus.readdatavalid);
        end
    endtask

    task automatic test_data_ops();
        do_write(0, 0, 32'h0F);
        total++;
        if (out_port[7:0] !== 8'h0F) begin
            bad++;
            $display("FAIL data_write: out=%h want 0f", out_port[7:0]);
        end
        do_write(0, 4, 32'hF0);
        total++;
        if (out_port[7:0] !== 8'hFF) begin
            bad++;
            $display("FAIL outset: out=%h want ff", out_port[7:0]);
        end
        do_write(0, 5, 32'h03);
        total++;
        if (out_port[7:0] !== 8'hFC) begin
            bad++;
            $display("FAIL outclr: out=%h want fc", out_port[7:0]);
        end
    endtask

    task automatic test_channels();
        logic [31:0] d;
        logic        v;
        do_write(1, 0, 32'h3C);
        total++;
        if (out_port[15:8] !== 8'h3C || out_port[7:0] !== 8'hFC) begin
            bad++;
            $display("FAIL chan1_write: out=%h want 3c/fc", out_port[15:0]);
        end
        do_read(3, 0, d, v);
        total++;
        if (d !== 32'h0 || v !== 1'b1) begin
            bad++;
            $display("FAIL chan3_read: data=%h vld=%b want 0/1", d, v);
        end
        do_read(1, 4, d, v);
        total++;
        if (d !== 32'h0 || v !== 1'b1) begin
            bad++;
            $display("FAIL wo_read: data=%h vld=%b want 0/1", d, v);
        end
        do_read(1, 6, d, v);
        total++;
        if (d !== 32'h0 || v !== 1'b1) begin
            bad++;
            $display("FAIL rsvd_read: data=%h vld=%b want 0/1", d, v);
        end
        do_write(3, 0, 32'hFF);
        total++;
        if (out_port !== exp_out()) begin
            bad++;
            $display("FAIL chan3_write: out=%h want %h", out_port, exp_out());
        end
        // both strobes low acts as a write only
        bus.address    = addr(2, 0);
        bus.writedata  = 32'h55;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.read_n     = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.read_n     = 1'b1;
        model_write(2, 0, 8'h55);
        total++;
        if (out_port[23:16] !== 8'h55 || bus.readdatavalid !== 1'b0) begin
            bad++;
            $display("FAIL rw_collide: out=%h vld=%b want 55/0",
                     out_port[23:16], bus.readdatavalid);
        end
    endtask

    task automatic test_in_sync();
        logic [31:0] d;
        logic        v;
        logic [23:0] old_v;
        logic [23:0] flip;
        old_v = in_port;
        flip  = 24'($urandom);
        flip[8] = 1'b1;
        in_port = old_v ^ flip;
        for (int k = 1; k <= 3; k++) begin
            do_read(1, 1, d, v);
            total++;
            if (d !== {24'h0, (k < 3) ? old_v[15:8] : in_port[15:8]}) begin
                bad++;
                $display("FAIL in_sync_%0d: data=%h want %h", k, d,
                         (k < 3) ? old_v[15:8] : in_port[15:8]);
            end
        end
`ifdef GOL_PIO_IRQ_EN
        for (int c = 0; c < NCH; c++)
            m_cap[c] = m_cap[c] | (in_port[c*8 +: 8] & ~old_v[c*8 +: 8]);
`endif
        tick(2);
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [31:0] e;
        logic        v;
        logic [23:0] nv;
        int          ch;
        int          off;
        for (int c = 0; c < NCH; c++) do_write(c, 3, 32'hFF);
        for (int ep = 0; ep < 6; ep++) begin
            nv = 24'($urandom);
`ifdef GOL_PIO_IRQ_EN
            for (int c = 0; c < NCH; c++)
                m_cap[c] = m_cap[c] | (nv[c*8 +: 8] & ~in_port[c*8 +: 8]);
`endif
            in_port = nv;
            tick(4);
            for (int op = 0; op < 25; op++) begin
                ch  = $urandom_range(0, 3);
                off = $urandom_range(0, 7);
                if ($urandom_range(0, 1) == 1) begin
                    do_write(ch, off, $urandom);
                    total++;
                    if (out_port !== exp_out()) begin
                        bad++;
                        $display("FAIL rnd_write ch%0d off%0d: out=%h want %h",
                                 ch, off, out_port, exp_out());
                    end
                end else begin
                    e = exp_read(ch, off);
                    do_read(ch, off, d, v);
                    total++;
                    if (d !== e || v !== 1'b1) begin
                        bad++;
                        $display("FAIL rnd_read ch%0d off%0d: data=%h vld=%b want %h/1",
                                 ch, off, d, v, e);
                    end
                end
            end
            tick(1);
            total++;
            if (irq !== exp_irq()) begin
                bad++;
                $display("FAIL rnd_irq ep%0d: irq=%b want %b", ep, irq, exp_irq());
            end
        end
    endtask

`ifdef GOL_PIO_IRQ_EN
    task automatic test_irq();
        logic [31:0] d;
        logic        v;
        in_port = '0;
        tick(5);
        for (int c = 0; c < NCH; c++) do_write(c, 3, 32'hFF);
        do_write(0, 2, 32'h01);
        do_write(1, 2, 32'h00);
        do_write(2, 2, 32'h00);
        tick(1);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_idle: irq=%b want 0", irq);
        end
        in_port[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (irq !== (k == 4)) begin
                bad++;
                $display("FAIL irq_latency_%0d: irq=%b want %b", k, irq, k == 4);
            end
        end
        do_read(0, 3, d, v);
        total++;
        if (d !== 32'h1) begin
            bad++;
            $display("FAIL edgecap_set: data=%h want 1", d);
        end
        do_write(0, 3, 32'h01);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_w1c_edge: irq=%b want 1", irq);
        end
        tick(1);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_clear: irq=%b want 0", irq);
        end
        in_port[0] = 1'b0;
        tick(5);
        do_read(0, 3, d, v);
        total++;
        if (d !== 32'h0 || irq !== 1'b0) begin
            bad++;
            $display("FAIL no_fall_cap: data=%h irq=%b want 0/0", d, irq);
        end
        in_port[0] = 1'b1;
        tick(4);
        in_port[0] = 1'b0;
        tick(5);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_sticky: irq=%b want 1", irq);
        end
        // clear lands on the same edge that detects the new rise
        in_port[0] = 1'b1;
        tick(2);
        do_write(0, 3, 32'h01);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL collide_irq0: irq=%b want 1", irq);
        end
        do_read(0, 3, d, v);
        total++;
        if (d !== 32'h1 || irq !== 1'b1) begin
            bad++;
            $display("FAIL collide_cap: data=%h irq=%b want 1/1", d, irq);
        end
    endtask
`else
    task automatic test_noirq();
        logic [31:0] d;
        logic        v;
        for (int k = 0; k < 12; k++) begin
            if (k % 2 == 0) in_port[0] = ~in_port[0];
            tick(1);
            total++;
            if (irq !== 1'b0) begin
                bad++;
                $display("FAIL noirq_irq_%0d: irq=%b want 0", k, irq);
            end
        end
        do_write(0, 2, 32'hFF);
        do_read(0, 2, d, v);
        total++;
        if (d !== 32'h0 || v !== 1'b1) begin
            bad++;
            $display("FAIL noirq_mask: data=%h vld=%b want 0/1", d, v);
        end
        do_read(0, 3, d, v);
        total++;
        if (d !== 32'h0 || v !== 1'b1) begin
            bad++;
            $display("FAIL noirq_cap: data=%h vld=%b want 0/1", d, v);
        end
    endtask
`endif

    initial begin
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.read_n     = 1'b1;
        bus.writedata  = '0;
        in_port        = '0;
        reset          = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            m_data[c] = 8'hA5;
            m_mask[c] = 8'h00;
            m_cap[c]  = 8'h00;
        end
        test_reset();
        test_data_ops();
        test_channels();
        test_in_sync();
        test_random();
`ifdef GOL_PIO_IRQ_EN
        test_irq();
`else
        test_noirq();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
